// File: rtl/reg_mux_unit.sv
// Loadable up/down counting register whose own bits drive a 4:1 bit mux.
// out is the register itself; mux_out is a combinational tap of it.

module reg_mux4 (
  input  logic [1:0] sel,
  input  logic       d0,
  input  logic       d1,
  input  logic       d2,
  input  logic       d3,
  output logic       y
);

  // Explicit 4:1 select; default keeps the output known on any select value.
  always_comb begin
    y = 1'b0;
    case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      2'd3:    y = d3;
      default: y = 1'b0;
    endcase
  end

endmodule

module reg_mux_unit #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             inc,
  input  logic             dec,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             mux_out
);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next_s;
  logic [1:0]       sel_s;
  logic [WIDTH-1:0] one_s;

  assign one_s = {{(WIDTH-1){1'b0}}, 1'b1};

  // Next-state selection: load beats counting; inc and dec together cancel.
  always_comb begin
    q_next_s = q_r;
    if (ld) begin
      q_next_s = in;
    end else if (inc && !dec) begin
      q_next_s = q_r + one_s;
    end else if (dec && !inc) begin
      q_next_s = q_r - one_s;
    end else begin
      q_next_s = q_r;
    end
  end

  // State register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r <= {WIDTH{1'b0}};
    end else begin
      q_r <= q_next_s;
    end
  end

  assign out = q_r;

  // q[0] is the select MSB, q[1] the select LSB.
  assign sel_s = {q_r[0], q_r[1]};

  reg_mux4 u_mux (
    .sel (sel_s),
    .d0  (q_r[2]),
    .d1  (q_r[3]),
    .d2  (q_r[4]),
    .d3  (q_r[4]),
    .y   (mux_out)
  );

endmodule

// File: tb/tb_reg_mux_unit.sv
// Randomized self-checking bench for reg_mux_unit against a behavioural model.

module tb_reg_mux_unit;

  localparam int WIDTH = 6;
  localparam int MODV  = 64;

  logic             clk;
  logic             rst;
  logic             ld;
  logic             inc;
  logic             dec;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;
  logic             mux_out;

  int checks;
  int failures;
  int ref_q;

  reg_mux_unit #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .ld      (ld),
    .inc     (inc),
    .dec     (dec),
    .in      (in),
    .out     (out),
    .mux_out (mux_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Selected bit described by the priority form of the mux rule.
  function automatic int ref_mux(input int q);
    if ((q % 2) == 1)            return (q / 16) % 2;
    else if (((q / 2) % 2) == 1) return (q / 8) % 2;
    else                         return (q / 4) % 2;
  endfunction

  function automatic int ref_next(input int q, input int l, input int i, input int d, input int v);
    if (l != 0)                 return v;
    else if (i != 0 && d != 0)  return q;
    else if (i != 0)            return (q + 1) % MODV;
    else if (d != 0)            return (q + MODV - 1) % MODV;
    else                        return q;
  endfunction

  // Drive controls between edges, clock once, then compare against the model.
  task automatic step(input int l, input int i, input int d, input int v, input string tag);
    @(negedge clk);
    ld  = l[0];
    inc = i[0];
    dec = d[0];
    in  = v[WIDTH-1:0];
    @(posedge clk);
    #1;
    ref_q = ref_next(ref_q, l, i, d, v);
    chk({tag, "_out"}, 32'(out), 32'(ref_q));
    chk({tag, "_mux"}, 32'(mux_out), 32'(ref_mux(ref_q)));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    ref_q    = 0;
    rst = 1'b0; ld = 1'b0; inc = 1'b0; dec = 1'b0; in = '0;

    // Reset holds zero regardless of controls.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      ld  = 1'($urandom);
      inc = 1'($urandom);
      dec = 1'($urandom);
      in  = WIDTH'($urandom);
      @(posedge clk);
      #1;
      chk("rst_out", 32'(out), 32'd0);
      chk("rst_mux", 32'(mux_out), 32'd0);
    end
    @(negedge clk);
    ld = 1'b0; inc = 1'b1; dec = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_release_hold", 32'(out), 32'd0);
    @(posedge clk);
    #1;
    ref_q = 1;
    chk("rst_first_edge", 32'(out), 32'd1);

    // Load paths through each mux select.
    step(1, 0, 0, 20, "ld20");
    chk("ld20_mux_q2", 32'(mux_out), 32'd1);
    step(1, 0, 0, 10, "ld10");
    chk("ld10_mux_q3", 32'(mux_out), 32'd1);
    step(1, 0, 0, 17, "ld17");
    chk("ld17_mux_q4", 32'(mux_out), 32'd1);
    step(1, 0, 0, 3, "ld3");
    chk("ld3_mux_q4", 32'(mux_out), 32'd0);

    // Wrap-around both directions.
    step(1, 0, 0, 63, "ld63");
    step(0, 1, 0, 0, "wrap_up");
    chk("wrap_up_zero", 32'(out), 32'd0);
    step(0, 0, 1, 0, "wrap_dn");
    chk("wrap_dn_63", 32'(out), 32'd63);
    chk("wrap_dn_mux", 32'(mux_out), 32'd1);

    // Priority ordering.
    step(1, 0, 0, 5, "ld5");
    step(1, 1, 1, 40, "prio_ld");
    chk("prio_ld_40", 32'(out), 32'd40);
    step(0, 1, 1, 0, "prio_hold");
    chk("prio_hold_40", 32'(out), 32'd40);
    step(0, 1, 0, 0, "prio_inc");
    chk("prio_inc_41", 32'(out), 32'd41);

    // Asynchronous reset between edges while counting.
    step(1, 0, 0, 37, "ld37");
    @(negedge clk);
    ld = 1'b0; inc = 1'b1; dec = 1'b0;
    @(posedge clk);
    #1;
    ref_q = 38;
    chk("count_38", 32'(out), 32'd38);
    #2;
    rst = 1'b0;
    #1;
    ref_q = 0;
    chk("async_clr", 32'(out), 32'd0);
    @(posedge clk);
    #1;
    chk("async_hold", 32'(out), 32'd0);
    @(negedge clk);
    inc = 1'b0;
    rst = 1'b1;

    // Randomized traffic, light on loads so counting paths get exercised.
    for (int k = 0; k < 100; k++) begin
      step(($urandom_range(0, 3) == 0) ? 1 : 0, int'($urandom_range(0, 1)),
           int'($urandom_range(0, 1)), int'($urandom_range(0, MODV - 1)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_mux_unit.md
Name: reg_mux_unit

Overview:
Combines a loadable up/down counting register with a 4:1 bit multiplexer. The mux select and data inputs are taken from the register's own output bits. The block produces a registered value plus a single combinational status bit derived from it. It is used as a small datapath element: the register state, and a bit selected by that state.

Parameters:
WIDTH, 6, register width in bits; must be >= 5 because the mux taps bits 0..4.

Ports:
clk  input  1  system clock; rising-edge active.
rst  input  1  asynchronous active-low reset.
ld  input  1  synchronous load enable.
inc  input  1  synchronous increment enable.
dec  input  1  synchronous decrement enable.
in  input  WIDTH  parallel load data.
out  output  WIDTH  register contents, q.
mux_out  output  1  selected bit from the 4:1 mux.

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-low (rst).
- Reset:
  - rst=0 clears q to 0 immediately, without waiting for a clock edge.
  - q holds 0 while rst=0; all control inputs are ignored.
  - With q=0, mux_out=0.
- Register update on rising clk edge when rst=1, by priority:
  1. ld=1: q <= in. inc and dec are ignored.
  2. else inc=1 and dec=1: q holds.
  3. else inc=1: q <= q+1, modulo 2^WIDTH (63 -> 0 for WIDTH=6).
  4. else dec=1: q <= q-1, modulo 2^WIDTH (0 -> 63).
  5. else: q holds.
- Latency and output path:
  - One cycle from control/in sampling to the new q.
  - out is driven directly from q; there is no extra output stage.
- Mux (4:1, purely combinational):
  - Select s is 2 bits: s[1]=q[0], s[0]=q[1]. The LSB of q is the select MSB.
  - Data inputs: in0=q[2], in1=q[3], in2=q[4], in3=q[4].
  - s=0 -> mux_out=q[2]; s=1 -> q[3]; s=2 -> q[4]; s=3 -> q[4].
  - Equivalently: q[0]=1 -> q[4]; q[0]=0,q[1]=1 -> q[3]; q[0]=0,q[1]=0 -> q[2].
  - mux_out follows q within the same cycle; it is not registered.
  - Implement as an explicit 4:1 mux submodule instance with no X-propagation on valid selects.
- Control inputs are sampled only at the clk edge. Changes between edges have no effect on q.
- Asserting rst mid-operation overrides any pending ld/inc/dec. The first update after rst rises occurs at the next rising edge.
- There is no reset synchronizer inside this block; release synchronization is the integrator's responsibility.

Test Plan:
1. Reset: rst=0 with random ld/inc/dec/in and clk toggling -> out=000000, mux_out=0 throughout; rst=1 -> still 0 until the next edge.
2. Load/mux paths, each with ld=1 and one edge:
   - in=010100 (20) -> out=20; s=0, mux_out=q[2]=1.
   - in=001010 (10) -> s=1, mux_out=q[3]=1.
   - in=010001 (17) -> s=2, mux_out=q[4]=1.
   - in=000011 (3) -> s=3, mux_out=q[4]=0.
3. Wrap-around:
   - load 63, inc=1 for one edge -> out=0, mux_out=0.
   - at 0, dec=1 for one edge -> out=63, mux_out=1.
4. Priority:
   - q=5 with ld=1,inc=1,dec=1, in=40 -> out=40.
   - q=40 with ld=0,inc=1,dec=1 -> out stays 40.
   - q=40 with inc=1 only -> 41.
5. Async reset mid-count: q=37 counting up, drop rst between edges -> out becomes 0 before the next edge and stays 0 while rst=0.
6. Randomized: 100 cycles of random ld/inc/dec/in, compared each edge against a reference model of the priority and modulo rules, plus a combinational check of mux_out.
